// File: rtl/mips_pkg.sv
// Shared widths, register-index constants and basic types for the MIPS datapath.
package mips_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_AT   = 5'd1;
   localparam reg_idx_t REG_SP   = 5'd29;
   localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_regfile_rdport.sv
// One combinational read port: selects a register by index, with index 0 forced to zero.
module mips_regfile_rdport
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W   = mips_pkg::DATA_W,
   parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
   parameter int unsigned NUM_REGS = mips_pkg::NUM_REGS
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]               rd_idx,
   output logic [DATA_W-1:0]               rd_data
);

   // Zero-index override sits in front of the mux so $0 never depends on storage.
   always_comb begin
      rd_data = '0;
      if (rd_idx != REG_ZERO) begin
         rd_data = regs[rd_idx];
      end
   end

endmodule

// File: rtl/mips_registers.sv
// 32 x 32-bit MIPS general-purpose register file: two async read ports, one sync write port.
// Register $0 has no storage and always reads as zero.
module mips_registers
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W   = mips_pkg::DATA_W,
   parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
   parameter int unsigned NUM_REGS = mips_pkg::NUM_REGS  // must equal 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg_1,
   input  logic [ADDR_W-1:0] read_reg_2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic              signal_reg_write
);

   // Flattened view of the file for the read muxes; slot 0 is a constant.
   logic [NUM_REGS-1:0][DATA_W-1:0] regs;

   assign regs[0] = '0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : gen_reg
      logic [DATA_W-1:0] mem_q;

      // Per-register flop: async clear, load when addressed by an enabled write.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem_q <= '0;
         end else if (signal_reg_write && (write_reg == ADDR_W'(i))) begin
            mem_q <= write_data;
         end
      end

      assign regs[i] = mem_q;
   end

   // No write-to-read bypass: a same-index read shows the new value only after the edge.
   mips_regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rdport_1 (
      .regs    (regs),
      .rd_idx  (read_reg_1),
      .rd_data (read_data_1)
   );

   mips_regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rdport_2 (
      .regs    (regs),
      .rd_idx  (read_reg_2),
      .rd_data (read_data_2)
   );

endmodule

// File: tb/tb_mips_registers.sv
// Self-checking bench for mips_registers: directed test-plan items plus randomized traffic
// checked against an array-based reference model.
module tb_mips_registers;
   import mips_pkg::*;

   logic     clk = 1'b0;
   logic     rst_n;
   word_t    read_data_1, read_data_2, write_data;
   reg_idx_t read_reg_1, read_reg_2, write_reg;
   logic     signal_reg_write;

   int checks = 0;
   int errors = 0;

   // Reference: plain array; entry 0 is never written so it stays zero.
   logic [31:0] model [32];

   always #5 clk = ~clk;

   mips_registers dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .read_data_1      (read_data_1),
      .read_data_2      (read_data_2),
      .write_data       (write_data),
      .read_reg_1       (read_reg_1),
      .read_reg_2       (read_reg_2),
      .write_reg        (write_reg),
      .signal_reg_write (signal_reg_write)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // One rising edge; the model takes the write only if reset is released and index != 0.
   task automatic tick();
      @(posedge clk);
      if (rst_n && signal_reg_write && write_reg != 5'd0) model[write_reg] = write_data;
      #1;
   endtask

   task automatic read_both(input string tag, input reg_idx_t a, input reg_idx_t b);
      read_reg_1 = a;
      read_reg_2 = b;
      #1;
      check({tag, "_p1"}, read_data_1, model[a]);
      check({tag, "_p2"}, read_data_2, model[b]);
   endtask

   initial begin
      rst_n            = 1'b0;
      signal_reg_write = 1'b0;
      write_reg        = '0;
      write_data       = '0;
      read_reg_1       = '0;
      read_reg_2       = 5'd1;
      model_clear();
      #12 rst_n = 1'b1;

      // Reset then read
      #1;
      check("reset_r0", read_data_1, 32'h0);
      check("reset_r1", read_data_2, 32'h0);

      // Basic write/read
      write_reg = 5'd2; write_data = 32'h8EFDFBF7; signal_reg_write = 1'b1;
      tick();
      signal_reg_write = 1'b0;
      read_reg_1 = 5'd2; read_reg_2 = 5'd1; #1;
      check("basic_r2", read_data_1, 32'h8EFDFBF7);
      check("basic_r1", read_data_2, 32'h0);
      read_reg_1 = 5'd0; #1;
      check("basic_r0", read_data_1, 32'h0);

      // Zero register discards writes
      write_reg = 5'd0; write_data = 32'hFFFFFFFF; signal_reg_write = 1'b1;
      tick();
      signal_reg_write = 1'b0;
      read_reg_1 = 5'd0; #1;
      check("zero_reg", read_data_1, 32'h0);

      // Write disabled
      write_reg = 5'd3; write_data = 32'h12345678; signal_reg_write = 1'b0;
      tick();
      read_reg_2 = 5'd3; #1;
      check("wr_disabled", read_data_2, 32'h0);

      // Dual port and read-during-write
      signal_reg_write = 1'b1;
      write_reg = 5'd31; write_data = 32'hDEADBEEF; tick();
      write_reg = 5'd5;  write_data = 32'h00000001; tick();
      signal_reg_write = 1'b0;
      read_reg_1 = 5'd31; read_reg_2 = 5'd5; #1;
      check("dual_r31", read_data_1, 32'hDEADBEEF);
      check("dual_r5", read_data_2, 32'h00000001);
      read_reg_1 = 5'd5; #1;
      check("same_idx", read_data_1, read_data_2);
      write_reg = 5'd5; write_data = 32'hA5A5A5A5; signal_reg_write = 1'b1; #1;
      check("rdw_before", read_data_1, 32'h00000001);
      tick();
      signal_reg_write = 1'b0;
      check("rdw_after", read_data_1, 32'hA5A5A5A5);

      // Fill every register with its own index
      signal_reg_write = 1'b1;
      for (int i = 1; i < 32; i++) begin
         write_reg = reg_idx_t'(i); write_data = 32'(i); tick();
      end
      signal_reg_write = 1'b0;
      for (int i = 0; i < 32; i++) begin
         read_reg_1 = reg_idx_t'(i); read_reg_2 = reg_idx_t'(31 - i); #1;
         check("fill_p1", read_data_1, 32'(i));
         check("fill_p2", read_data_2, 32'(31 - i));
      end

      // Async reset between edges: reads drop to zero without a clock edge
      #1 rst_n = 1'b0;
      model_clear();
      #1;
      for (int i = 0; i < 32; i++) begin
         read_reg_1 = reg_idx_t'(i); read_reg_2 = reg_idx_t'(31 - i); #1;
         check("async_rst_p1", read_data_1, 32'h0);
         check("async_rst_p2", read_data_2, 32'h0);
      end
      // Writes while held in reset are ignored
      write_reg = 5'd7; write_data = 32'hCAFEF00D; signal_reg_write = 1'b1;
      tick();
      signal_reg_write = 1'b0;
      read_reg_1 = 5'd7; #1;
      check("rst_blocks_wr", read_data_1, 32'h0);
      #1 rst_n = 1'b1;

      // Randomized traffic against the model, with the occasional mid-cycle reset pulse
      for (int n = 0; n < 400; n++) begin
         write_reg        = reg_idx_t'($urandom_range(0, 31));
         write_data       = $urandom;
         signal_reg_write = ($urandom_range(0, 3) != 0);
         read_both("rand_pre", reg_idx_t'($urandom_range(0, 31)),
                   reg_idx_t'($urandom_range(0, 31)));
         tick();
         read_both("rand_post", write_reg, reg_idx_t'($urandom_range(0, 31)));
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            model_clear();
            #1;
            read_both("rand_rst", reg_idx_t'($urandom_range(0, 31)),
                      reg_idx_t'($urandom_range(0, 31)));
            rst_n = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
